// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default baud divisor.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 27;  // 27 MHz clock at 1 Mbaud

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
`timescale 1ns/1ps
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both preset to the line's idle level on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, mid-bit sampling, single-byte holding register with
// valid/ready handshake, frame-error and overrun pulses.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  uart_state_t          state;
  logic                 rxs;
  logic                 rxs_d;
  logic [1:0]           primed;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (RXD),
    .q   (rxs)
  );

  assign busy = (state != IDLE);

  // Receive FSM with registered data, handshake and pulse outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      rxs_d     <= 1'b0;
      primed    <= 2'b00;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // The synchronizer flops come out of reset holding 1, so the first two
      // samples are not the real line. The edge-detect history is held low
      // until real samples arrive; a line held low through reset then never
      // looks like a falling edge.
      primed    <= {primed[0], 1'b1};
      rxs_d     <= primed[1] ? rxs : 1'b0;

      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (rxs_d && !rxs) begin
            state <= START;
          end
        end

        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            state    <= rxs ? IDLE : DATA;  // high at mid-start: glitch
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            shift    <= {rxs, shift[DATA_BITS-1:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            if (rxs) begin
              // Leave at mid-stop so a back-to-back start edge is caught.
              state <= IDLE;
              if (rx_valid && !rx_ready) begin
                overrun <= 1'b1;
              end else begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        WAIT_HIGH: begin
          if (rxs) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 27, meaning CLK cycles per UART bit (27 MHz clock at 1 Mbaud); legal range is 4 to 65535.
- REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all logic runs on its rising edge.
- REQ-003 The block SHALL have port RST, input, 1 bit; reset is asynchronous and active-high.
- REQ-004 The block SHALL have port RXD, input, 1 bit, an asynchronous serial line that idles high.
- REQ-005 The block SHALL have port rx_data, output, 8 bits, the received byte.
- REQ-006 The block SHALL have port rx_valid, output, 1 bit; high means rx_data holds an unconsumed byte.
- REQ-007 The block SHALL have port rx_ready, input, 1 bit; the consumer accepts the byte when it is high.
- REQ-008 The block SHALL have port frame_err, output, 1 bit, a 1-cycle pulse on a bad stop bit.
- REQ-009 The block SHALL have port overrun, output, 1 bit, a 1-cycle pulse when a completed byte is dropped.
- REQ-010 The block SHALL have port busy, output, 1 bit; it is high in every state except IDLE.

Function
- REQ-011 RXD SHALL pass through a 2-FF synchronizer before use; this adds 2 cycles of latency, and all timing below refers to the synchronized signal rxs.
- REQ-012 The state machine SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH.
- REQ-013 In IDLE, a 1-to-0 transition on rxs SHALL move the FSM to START and clear the bit counter.
- REQ-014 In START, after CLKS_PER_BIT/2 cycles (integer division), the FSM SHALL sample rxs: 0 moves to DATA; 1 is a glitch and returns to IDLE with no error output.
- REQ-015 In DATA, the FSM SHALL sample rxs every CLKS_PER_BIT cycles, 8 samples in all, shifting them in LSB first, then move to STOP.
- REQ-016 In STOP, the FSM SHALL sample rxs after CLKS_PER_BIT cycles: 1 is a good frame and returns to IDLE at once, at mid-stop, so a back-to-back start bit is caught; 0 pulses frame_err, discards the byte and moves to WAIT_HIGH.
- REQ-017 WAIT_HIGH SHALL return to IDLE on the first cycle with rxs=1, so a break condition yields exactly one frame_err.
- REQ-018 On a good frame, rx_data and rx_valid SHALL update on the cycle after the stop sample.
- REQ-019 rx_valid SHALL stay high, and rx_data stay stable, until a cycle with rx_valid=1 and rx_ready=1; rx_valid clears on the next edge.
- REQ-020 If a good frame completes while rx_valid=1 and rx_ready=0, the new byte SHALL be dropped, the old byte kept, and overrun pulsed.
- REQ-021 If a good frame completes in the same cycle that the held byte is accepted, the new byte SHALL be loaded, rx_valid SHALL stay 1, and overrun SHALL NOT pulse.
- REQ-022 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL reload to 0 at every sample point, with no accumulated drift.
- REQ-023 rx_ready SHALL be ignored while rx_valid=0.

Reset
- REQ-024 On RST=1 the block SHALL asynchronously force: FSM IDLE, both synchronizer FFs 1, counters 0, rx_data 8'h00, rx_valid 0, frame_err 0, overrun 0, busy 0.
- REQ-025 RST asserted mid-frame SHALL abort the frame with no output pulse.
- REQ-026 After RST deasserts with RXD held low, no frame SHALL start until a 1-to-0 transition is seen.

Structure
- REQ-027 The state enum, DATA_BITS=8 and the default CLKS_PER_BIT SHALL live in the shared package uart_pkg, for reuse by the future uart_tx.
- REQ-028 The synchronizer SHALL be sub-module sync_2ff (parameter RESET_VAL=1); everything else stays in uart_rx.

Verification
- REQ-029 Bench settings SHALL be CLK period 37.04 ns, CLKS_PER_BIT=27 and 1000 ns bit time.
- REQ-030 Drive RXD start, bits 0,1,0,1,0,1,0,1, stop, with rx_ready=1 -> rx_data=8'hAA and rx_valid high for exactly 1 cycle.
- REQ-031 Send 8'hAA twice back-to-back with no idle gap and rx_ready=0 -> the first byte is held, overrun pulses once, rx_data stays 8'hAA.
- REQ-032 Send 8'h55 with stop bit 0, then hold RXD low for 5 bit times -> one frame_err pulse, rx_valid stays 0, busy stays high until RXD returns high.
- REQ-033 Drive a 300 ns low glitch on RXD -> no rx_valid and no frame_err; busy returns to 0 within 16 cycles.
- REQ-034 Assert RST after data bit 3 of a frame -> all outputs go to reset values at once; a following clean 8'h3C frame is received correctly.
- REQ-035 Send 8'h0F with rx_ready asserted exactly on the cycle the new rx_valid would load (held byte 8'hAA present) -> 8'hAA is accepted, 8'h0F is loaded, no overrun.
